// File: rtl/seq_div_32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_32_pkg
// Description : Shared constants and the state type for the iterative
//               32-bit restoring divider and its trial subtractor.
//               No ports (package).
// Revision    : 1.0 - initial release
// ============================================================================
package seq_div_32_pkg;

  localparam int unsigned DIV_W = 32;

  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } div_state_e;

endpackage : seq_div_32_pkg
`default_nettype wire

// File: rtl/seq_div_32_cls.sv
`default_nettype none
// ============================================================================
// Module      : PG2B / CLS_32bit
// Description : 32-bit carry-lookahead subtractor, diff = a - b - bin.
//               Subtraction is done as a + ~b + ~bin. Bits are grouped in
//               nibbles with full lookahead inside each group. PG2B turns the
//               group generate/propagate terms into group carry-ins and the
//               final borrow.
// Ports (PG2B)      : g_i/p_i group G/P, bin_i borrow in,
//                     c_o group carry-ins, bout_o borrow out
// Ports (CLS_32bit) : a_i minuend, b_i subtrahend, bin_i borrow in,
//                     diff_o difference, bout_o borrow out
// Revision    : 1.0 - initial release
// ============================================================================
module PG2B
  import seq_div_32_pkg::*;
#(
  parameter int unsigned NGRP = DIV_W / 4
) (
  input  logic [NGRP-1:0] g_i,
  input  logic [NGRP-1:0] p_i,
  input  logic            bin_i,
  output logic [NGRP-1:0] c_o,
  output logic            bout_o
);

  logic [NGRP:0] c_chain;

  always_comb begin
    // A borrow in is the absence of the +1 carry in two's complement.
    c_chain    = '0;
    c_chain[0] = ~bin_i;
    for (int k = 0; k < int'(NGRP); k++) begin
      c_chain[k+1] = g_i[k] | (p_i[k] & c_chain[k]);
    end
  end

  assign c_o    = c_chain[NGRP-1:0];
  assign bout_o = ~c_chain[NGRP];

endmodule : PG2B

module CLS_32bit
  import seq_div_32_pkg::*;
(
  input  logic [DIV_W-1:0] a_i,
  input  logic [DIV_W-1:0] b_i,
  input  logic             bin_i,
  output logic [DIV_W-1:0] diff_o,
  output logic             bout_o
);

  localparam int unsigned NGRP = DIV_W / 4;

  logic [DIV_W-1:0] p_w;
  logic [DIV_W-1:0] g_w;
  logic [DIV_W-1:0] c_w;
  logic [NGRP-1:0]  grp_g_w;
  logic [NGRP-1:0]  grp_p_w;
  logic [NGRP-1:0]  grp_c_w;

  assign p_w = a_i ^ ~b_i;
  assign g_w = a_i & ~b_i;

  for (genvar k = 0; k < int'(NGRP); k++) begin : g_grp
    localparam int unsigned B = 4 * k;

    assign grp_g_w[k] = g_w[B+3]
                      | (p_w[B+3] & g_w[B+2])
                      | (p_w[B+3] & p_w[B+2] & g_w[B+1])
                      | (p_w[B+3] & p_w[B+2] & p_w[B+1] & g_w[B]);
    assign grp_p_w[k] = &p_w[B+3:B];

    assign c_w[B]   = grp_c_w[k];
    assign c_w[B+1] = g_w[B] | (p_w[B] & grp_c_w[k]);
    assign c_w[B+2] = g_w[B+1] | (p_w[B+1] & g_w[B])
                    | (p_w[B+1] & p_w[B] & grp_c_w[k]);
    assign c_w[B+3] = g_w[B+2] | (p_w[B+2] & g_w[B+1])
                    | (p_w[B+2] & p_w[B+1] & g_w[B])
                    | (p_w[B+2] & p_w[B+1] & p_w[B] & grp_c_w[k]);
  end : g_grp

  PG2B #(
    .NGRP (NGRP)
  ) u_pg2b (
    .g_i    (grp_g_w),
    .p_i    (grp_p_w),
    .bin_i  (bin_i),
    .c_o    (grp_c_w),
    .bout_o (bout_o)
  );

  assign diff_o = p_w ^ c_w;

endmodule : CLS_32bit
`default_nettype wire

// File: rtl/seq_div_32.sv
`default_nettype none
// ============================================================================
// Module      : seq_div_32
// Description : Iterative unsigned 32-bit restoring divider, one quotient
//               bit per clock, using CLS_32bit as the trial subtractor.
// Ports       : clk          rising-edge clock
//               rst          asynchronous active-low reset
//               start        request, honoured in IDLE or DONE
//               dividend     unsigned dividend, latched on accept
//               divisor      unsigned divisor, latched on accept
//               busy         high while iterating
//               done         one-cycle result-valid pulse
//               quotient     registered quotient
//               remainder    registered remainder
//               div_by_zero  latched divisor was zero
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div_32
  import seq_div_32_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] d_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   sh_w;
  logic [WIDTH-1:0] diff_w;
  logic             bout_w;
  logic             borrow_w;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] r_d;

  // Shift the next dividend bit into the partial remainder.
  assign sh_w = {r_q, q_q[WIDTH-1]};

  CLS_32bit u_cls (
    .a_i    (sh_w[WIDTH-1:0]),
    .b_i    (d_q),
    .bin_i  (1'b0),
    .diff_o (diff_w),
    .bout_o (bout_w)
  );

  // A set top bit means the shifted remainder exceeds any 32-bit divisor,
  // so the subtraction always fits regardless of the 32-bit borrow.
  assign borrow_w = bout_w & ~sh_w[WIDTH];
  assign r_d      = borrow_w ? sh_w[WIDTH-1:0] : diff_w;
  assign q_d      = {q_q[WIDTH-2:0], ~borrow_w};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            d_q <= divisor;
            if (divisor != '0) begin
              q_q     <= dividend;
              r_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end else begin
              quot_q  <= DBZ_QUOTIENT;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_RUN: begin
          q_q <= q_d;
          r_q <= r_d;
          if (cnt_q == LAST_CNT) begin
            cnt_q   <= '0;
            quot_q  <= q_d;
            rem_q   <= r_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule : seq_div_32
`default_nettype wire

// File: tb/tb_seq_div_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div_32
// Description : Self-checking bench for seq_div_32. Results are compared
//               against plain integer division and fixed latency rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests;
  int n_fail;
  int done_seen;
  int accepts;

  seq_div_32 #(
    .WIDTH (32),
    .CNT_W (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands and pulse start across one rising edge; returns #1 after it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges until done is seen, and busy samples seen beforehand.
  task automatic wait_done(output int cycles, output int bcnt);
    cycles = 0;
    bcnt   = 0;
    while (done !== 1'b1 && cycles < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (done !== 1'b1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input bit check_lat);
    int cyc;
    int bc;
    issue(a, b);
    accepts++;
    wait_done(cyc, bc);
    if (b == 0) begin
      check({tag, "_q"}, quotient, 32'hFFFF_FFFF);
      check({tag, "_r"}, remainder, a);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd1);
    end else begin
      check({tag, "_q"}, quotient, a / b);
      check({tag, "_r"}, remainder, a % b);
      check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    end
    if (check_lat) begin
      check({tag, "_lat"}, cyc, (b == 0) ? 32'd0 : 32'd32);
      check({tag, "_busy"}, bc, (b == 0) ? 32'd0 : 32'd32);
    end
  endtask

  initial begin
    int cyc;
    int bc;
    int snap;
    logic [31:0] a;
    logic [31:0] b;

    n_tests   = 0;
    n_fail    = 0;
    done_seen = 0;
    accepts   = 0;
    rst       = 1'b0;
    start     = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Nominal, plus done must be a single-cycle pulse.
    run_and_check("nom", 32'd100, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    check("nom_pulse", {31'd0, done}, 32'd0);
    check("nom_hold_q", quotient, 32'd14);

    run_and_check("max_by1", 32'hFFFF_FFFF, 32'd1, 1'b1);
    run_and_check("max_bymax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_and_check("small", 32'd3, 32'd10, 1'b1);
    run_and_check("dbz", 32'd5, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    check("dbz_pulse", {31'd0, done}, 32'd0);

    // Start during RUN is ignored.
    issue(32'd1000, 32'd9);
    accepts++;
    repeat (9) @(posedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bc);
    check("ign_q", quotient, 32'd111);
    check("ign_r", remainder, 32'd1);

    // Back-to-back: start while in DONE.
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    accepts++;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done", {31'd0, done}, 32'd0);
    wait_done(cyc, bc);
    check("b2b_q", quotient, 32'd10);
    check("b2b_r", remainder, 32'd0);
    check("b2b_lat", cyc, 32'd32);

    // Asynchronous reset mid-run.
    issue(32'd12345, 32'd67);
    repeat (15) @(posedge clk);
    #2;
    snap = done_seen;
    rst  = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_q", quotient, 32'd0);
    check("arst_r", remainder, 32'd0);
    check("arst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    check("arst_nodone", done_seen - snap, 32'd0);
    run_and_check("after_rst", 32'd12345, 32'd67, 1'b1);

    // Random operands; the done count must track accepted starts.
    snap    = done_seen;
    accepts = 0;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = $urandom_range(255, 1);
        2:       b = $urandom >> $urandom_range(31, 0);
        default: b = a >> $urandom_range(8, 0);
      endcase
      if (b == 0) b = 32'd1;
      run_and_check("rnd", a, b, 1'b0);
    end
    @(negedge clk);
    check("done_count", done_seen - snap, accepts);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_div_32
`default_nettype wire
